mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 33 +++
 rtl/mem_port_arbiter_wait_timer.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM and owner encodings,
// default geometry, and the round-robin winner selection.
package mem_port_arbiter_pkg;

  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // On a tie the port that was not served last wins.
  function automatic owner_e pick_winner(input logic f_req, input logic d_req, input owner_e last);
    owner_e win;
    if (f_req && d_req) begin
      win = (last == OWN_D) ? OWN_F : OWN_D;
    end else if (f_req) begin
      win = OWN_F;
    end else begin
      win = OWN_D;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Access wait counter: counts cycles spent waiting for the memory and flags the
// cycle whose 1-based number equals TIMEOUT.
module wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic srst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // count_q holds completed wait cycles, so the current cycle number is count_q + 1.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-access memory port between a fetch
// requester and a data requester, with a bounded wait for memory ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          FReq,
  input  logic [AW-1:0] FAddr,
  output logic          FGnt,
  output logic          FAck,
  output logic [DW-1:0] FData,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic          DGnt,
  output logic          DAck,
  output logic [DW-1:0] DRData,
  output logic          Err,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemRdy
);

  state_e        state_q,  state_d;
  owner_e        owner_q,  owner_d;
  owner_e        last_q,   last_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic          we_q,     we_d;
  logic [DW-1:0] wdata_q,  wdata_d;
  logic          err_q,    err_d;
  logic [DW-1:0] fdata_q,  fdata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic          expired;
  logic          in_access;

  assign in_access = (state_q == ST_ACCESS);

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk      (CLK),
    .srst     (CLR),
    .clear_i  (!in_access),
    .enable_i (in_access),
    .expired_o(expired)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (FReq || DReq) state_d = ST_ACCESS;
      ST_ACCESS: if (MemRdy || expired) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Transfer context: operands are frozen at grant so later requester changes cannot leak in.
  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    fdata_d  = fdata_q;
    drdata_d = drdata_q;
    case (state_q)
      ST_IDLE: begin
        if (FReq || DReq) begin
          owner_d = pick_winner(FReq, DReq, last_q);
          if (owner_d == OWN_F) begin
            addr_d  = FAddr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = DAddr;
            we_d    = DWe;
            wdata_d = DWData;
          end
        end
      end
      ST_ACCESS: begin
        if (MemRdy || expired) begin
          // Ready wins over a coinciding timeout.
          err_d = !MemRdy;
          if (!we_q) begin
            if (owner_q == OWN_F) begin
              fdata_d = MemRdy ? MemRData : '0;
            end else begin
              drdata_d = MemRdy ? MemRData : '0;
            end
          end
        end
      end
      ST_RESP: begin
        last_d = owner_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      owner_q  <= OWN_F;
      last_q   <= OWN_D;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      fdata_q  <= '0;
      drdata_q <= '0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      fdata_q  <= fdata_d;
      drdata_q <= drdata_d;
    end
  end

  always_comb begin
    FGnt     = (state_q != ST_IDLE) && (owner_q == OWN_F);
    DGnt     = (state_q != ST_IDLE) && (owner_q == OWN_D);
    FAck     = (state_q == ST_RESP) && (owner_q == OWN_F);
    DAck     = (state_q == ST_RESP) && (owner_q == OWN_D);
    Err      = (state_q == ST_RESP) && err_q;
    MemEn    = in_access;
    MemWe    = in_access && we_q;
    MemAddr  = in_access ? addr_q : '0;
    MemWData = in_access ? wdata_q : '0;
    FData    = fdata_q;
    DRData   = drdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model predicts every
// output each cycle, and hand-computed literals pin the key scenarios.
module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic       CLK;
  logic       CLR;
  logic       FReq, DReq, DWe;
  logic [7:0] FAddr, DAddr, DWData;
  logic       FGnt, FAck, DGnt, DAck, Err;
  logic [7:0] FData, DRData;
  logic       MemEn, MemWe, MemRdy;
  logic [7:0] MemAddr, MemWData, MemRData;

  mem_port_arbiter #(.AW(8), .DW(8), .TIMEOUT(TO)) dut (
    .CLK(CLK), .CLR(CLR),
    .FReq(FReq), .FAddr(FAddr), .FGnt(FGnt), .FAck(FAck), .FData(FData),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DGnt(DGnt), .DAck(DAck), .DRData(DRData), .Err(Err),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemRdy(MemRdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory responder: ready on access cycle rdy_at (0 = never); unwritten words read as addr+0x93.
  int       rdy_at;
  int       acc_cnt;
  bit [7:0] tb_mem [256];
  bit       tb_wr  [256];

  assign MemRdy   = MemEn && (rdy_at != 0) && (acc_cnt + 1 == rdy_at);
  assign MemRData = tb_wr[MemAddr] ? tb_mem[MemAddr] : 8'(MemAddr + 8'h93);

  always @(posedge CLK) begin
    acc_cnt <= MemEn ? acc_cnt + 1 : 0;
    if (MemEn && MemWe && MemRdy) begin
      tb_mem[MemAddr] <= MemWData;
      tb_wr[MemAddr]  <= 1'b1;
    end
  end

  // Transaction model: a granted transfer spends len cycles on the bus, then one response cycle.
  bit       m_valid, m_active, m_owner, m_last, m_we, m_err;
  int       m_t, m_len;
  logic [7:0] m_addr, m_wdata, m_fdata, m_drdata;
  bit [7:0] m_mem [256];
  bit       m_wr  [256];

  function automatic bit winner(input bit f, input bit d, input bit last);
    return (f && d) ? !last : !f;
  endfunction

  always @(posedge CLK) begin
    if (CLR) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_t      <= 0;
      m_last   <= 1'b1;
      m_fdata  <= 8'h00;
      m_drdata <= 8'h00;
    end else if (!m_active) begin
      if (FReq || DReq) begin
        m_active <= 1'b1;
        m_t      <= 1;
        m_owner  <= winner(FReq, DReq, m_last);
        m_addr   <= winner(FReq, DReq, m_last) ? DAddr : FAddr;
        m_we     <= winner(FReq, DReq, m_last) ? DWe : 1'b0;
        m_wdata  <= winner(FReq, DReq, m_last) ? DWData : 8'h00;
        m_len    <= (rdy_at >= 1 && rdy_at <= TO) ? rdy_at : TO;
        m_err    <= !(rdy_at >= 1 && rdy_at <= TO);
      end
    end else if (m_t <= m_len) begin
      m_t <= m_t + 1;
      if (m_t == m_len) begin
        if (!m_we) begin
          if (m_owner == 1'b0) m_fdata <= m_err ? 8'h00 : (m_wr[m_addr] ? m_mem[m_addr] : 8'(m_addr + 8'h93));
          else                 m_drdata <= m_err ? 8'h00 : (m_wr[m_addr] ? m_mem[m_addr] : 8'(m_addr + 8'h93));
        end else if (!m_err) begin
          m_mem[m_addr] <= m_wdata;
          m_wr[m_addr]  <= 1'b1;
        end
      end
    end else begin
      m_active <= 1'b0;
      m_last   <= m_owner;
    end
  end

  int n_cmp;
  int n_fail;
  int gq[$];
  bit p_fgnt, p_dgnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sample();
    bit acc, rsp;
    @(negedge CLK);
    if (m_valid) begin
      acc = m_active && (m_t <= m_len);
      rsp = m_active && (m_t == m_len + 1);
      chk("FGnt",     FGnt,     m_active && !m_owner);
      chk("DGnt",     DGnt,     m_active && m_owner);
      chk("FAck",     FAck,     rsp && !m_owner);
      chk("DAck",     DAck,     rsp && m_owner);
      chk("Err",      Err,      rsp && m_err);
      chk("MemEn",    MemEn,    acc);
      chk("MemWe",    MemWe,    acc && m_we);
      chk("MemAddr",  MemAddr,  acc ? m_addr : 8'h00);
      chk("MemWData", MemWData, acc ? m_wdata : 8'h00);
      chk("FData",    FData,    m_fdata);
      chk("DRData",   DRData,   m_drdata);
    end
    if (FGnt && !p_fgnt) gq.push_back(0);
    if (DGnt && !p_dgnt) gq.push_back(1);
    p_fgnt = FGnt;
    p_dgnt = DGnt;
  endtask

  task automatic advance();
    @(posedge CLK);
    #2;
  endtask

  int         r_en;
  bit         r_we, r_ok, r_err, r_fack, r_dack;
  logic [7:0] r_fdata, r_drdata;

  task automatic run_until_ack(input int budget, input bit mutate, input int drop_after);
    r_en = 0;
    r_we = 0;
    r_ok = 0;
    for (int i = 0; i < budget && !r_ok; i++) begin
      sample();
      if (MemEn) begin
        r_en++;
        if (MemWe) r_we = 1;
      end
      if (FAck || DAck) begin
        r_ok = 1; r_err = Err; r_fack = FAck; r_dack = DAck;
        r_fdata = FData; r_drdata = DRData;
      end
      advance();
      if (r_ok) begin
        FReq = 0; DReq = 0;
      end else if (MemEn) begin
        if (mutate) begin DAddr = 8'h77; DWData = 8'hFF; end
        if (drop_after != 0 && r_en == drop_after) begin FReq = 0; DReq = 0; end
      end
    end
    chk("ack_seen", r_ok, 1);
  endtask

  int exp_order [4] = '{0, 1, 0, 1};
  int nacks;
  int stray;

  initial begin
    n_cmp = 0; n_fail = 0;
    CLR = 1; FReq = 1; DReq = 1; DWe = 0;
    FAddr = 8'h00; DAddr = 8'h00; DWData = 8'h00; rdy_at = 1;

    // Reset held two cycles with both requests asserted.
    advance();
    sample();
    chk("rst_FGnt", FGnt, 0); chk("rst_DGnt", DGnt, 0);
    chk("rst_MemEn", MemEn, 0); chk("rst_FData", FData, 0);
    advance();
    CLR = 0;

    // Contention from reset: grants alternate starting with fetch.
    nacks = 0;
    for (int i = 0; i < 40 && nacks < 4; i++) begin
      sample();
      if (FAck || DAck) nacks++;
      chk("no_overlap", FGnt && DGnt, 0);
      advance();
    end
    FReq = 0; DReq = 0;
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", gq[i], exp_order[i]);

    // Fetch read at minimum latency.
    FReq = 1; FAddr = 8'h12; rdy_at = 1;
    sample(); advance();
    sample();
    chk("f_MemEn", MemEn, 1); chk("f_MemAddr", MemAddr, 8'h12); chk("f_MemWe", MemWe, 0);
    advance();
    sample();
    chk("f_FAck", FAck, 1); chk("f_FData", FData, 8'hA5); chk("f_Err", Err, 0);
    advance();
    FReq = 0;

    // Data write with wait states; operands change after latch.
    DReq = 1; DWe = 1; DAddr = 8'h40; DWData = 8'h3C; rdy_at = 3;
    run_until_ack(40, 1, 0);
    chk("w_en_cycles", r_en, 3); chk("w_we", r_we, 1); chk("w_dack", r_dack, 1); chk("w_err", r_err, 0);

    // Read back the written word.
    DReq = 1; DWe = 0; DAddr = 8'h40; rdy_at = 1;
    run_until_ack(40, 0, 0);
    chk("rb_data", r_drdata, 8'h3C);

    // Ready on exactly the TIMEOUT cycle counts as success.
    DReq = 1; DWe = 0; DAddr = 8'h55; rdy_at = TO;
    run_until_ack(40, 0, 0);
    chk("edge_en", r_en, TO); chk("edge_err", r_err, 0); chk("edge_data", r_drdata, 8'hE8);

    // Timeout with request dropped mid-access.
    DReq = 1; DWe = 0; DAddr = 8'h56; rdy_at = 0;
    run_until_ack(40, 0, 2);
    chk("to_en", r_en, TO); chk("to_err", r_err, 1); chk("to_dack", r_dack, 1); chk("to_data", r_drdata, 8'h00);

    // Following access is unaffected.
    FReq = 1; FAddr = 8'h20; rdy_at = 1;
    run_until_ack(40, 0, 0);
    chk("post_fack", r_fack, 1); chk("post_err", r_err, 0); chk("post_data", r_fdata, 8'hB3);

    // Reset in the second access cycle abandons the transfer.
    FReq = 1; FAddr = 8'h30; rdy_at = 0;
    sample(); advance();
    sample(); advance();
    sample();
    chk("mr_MemEn_before", MemEn, 1);
    CLR = 1;
    advance();
    CLR = 0; FReq = 0;
    sample();
    chk("mr_MemEn", MemEn, 0); chk("mr_FGnt", FGnt, 0); chk("mr_FData", FData, 0);
    advance();
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (FAck || DAck || MemEn) stray++;
      advance();
    end
    chk("mr_no_ack", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
